simon_sequencer: RTL and testbench

SIMON_SEQUENCER -- requirements
Module: simon_sequencer

---
 rtl/simon_pkg.sv | 29 ++
 rtl/simon_lfsr.sv | 28 ++
 rtl/simon_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_simon_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared display codes, FSM state encoding and small helpers for the Simon sequencer.
package simon_pkg;

    localparam logic [3:0] CODE_BOARD  = 4'd0;
    localparam logic [3:0] CODE_RED    = 4'd1;
    localparam logic [3:0] CODE_BLUE   = 4'd2;
    localparam logic [3:0] CODE_YELLOW = 4'd3;
    localparam logic [3:0] CODE_GREEN  = 4'd4;
    localparam logic [3:0] CODE_LOSE   = 4'd5;
    localparam logic [3:0] CODE_WIN    = 4'd6;
    localparam logic [3:0] CODE_START  = 4'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD   = 3'd1,
        SHOW  = 3'd2,
        GAP   = 3'd3,
        INPUT = 3'd4,
        ECHO  = 3'd5,
        LOSE  = 3'd6,
        WIN   = 3'd7
    } state_e;

    // A stored 2-bit entry v is displayed as color code v+1.
    function automatic logic [3:0] entry_to_code(input logic [1:0] v);
        return {2'b00, v} + 4'd1;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); the seed is captured only while rst is high.
module simon_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // Next LFSR state: shift left, feedback from the tap positions.
    always_comb begin
        value_d = {value_q[6:0], value_q[7] ^ value_q[5] ^ value_q[4] ^ value_q[3]};
    end

    // LFSR register; an all-zero seed would lock up, so it loads 8'h01 instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= (seed == 8'h00) ? 8'h01 : seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/simon_sequencer.sv
// Simon memory game: grows a random color sequence, plays it back, then checks the player's echo.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int SHOW_TICKS = 4,
    parameter int GAP_TICKS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       btn_u,
    input  logic       btn_r,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic [7:0] seed,
    output logic [3:0] g_color_num,
    output logic [4:0] level,
    output logic       awaiting_input
);

    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int CW   = $clog2(TMAX + 1);

    state_e          state_q, state_d;
    logic [4:0]      level_q, level_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      color_q, color_d;
    logic            await_q, await_d;
    logic            start_q;

    logic [1:0]      mem_q [0:MAX_LEN-1];
    logic            mem_we_s;
    logic [IW-1:0]   mem_widx_s;

    logic [7:0]      lfsr_s;
    logic            unused_lfsr_s;
    logic            press_valid_s;
    logic [1:0]      press_val_s;
    logic            rise_s;
    logic            fall_s;
    logic            more_s;
    logic [1:0]      show_val_s;

    simon_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (seed),
        .value (lfsr_s)
    );

    assign unused_lfsr_s = ^lfsr_s[7:2];
    assign rise_s        = start & ~start_q;
    assign fall_s        = ~start & start_q;
    assign mem_widx_s    = level_q[IW-1:0];
    assign more_s        = (6'(idx_q) + 6'd1) < 6'(level_q);

    // Button encoder with fixed priority u > r > d > l; value is the stored-entry form.
    always_comb begin
        if (btn_u) begin
            press_valid_s = 1'b1;
            press_val_s   = 2'd0;
        end else if (btn_r) begin
            press_valid_s = 1'b1;
            press_val_s   = 2'd1;
        end else if (btn_d) begin
            press_valid_s = 1'b1;
            press_val_s   = 2'd2;
        end else if (btn_l) begin
            press_valid_s = 1'b1;
            press_val_s   = 2'd3;
        end else begin
            press_valid_s = 1'b0;
            press_val_s   = 2'd0;
        end
    end

    // Next-state logic; outputs are derived from the next state so they land with it.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        mem_we_s   = 1'b0;
        color_d    = color_q;
        await_d    = 1'b0;
        show_val_s = 2'd0;

        case (state_q)
            IDLE: begin
                level_d = 5'd0;
                idx_d   = '0;
                cnt_d   = '0;
                if (rise_s) begin
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                mem_we_s = 1'b1;
                level_d  = (level_q < 5'(MAX_LEN)) ? level_q + 5'd1 : level_q;
                idx_d    = '0;
                cnt_d    = '0;
                state_d  = SHOW;
            end
            SHOW: begin
                if (tick && (cnt_q == CW'(SHOW_TICKS - 1))) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            GAP: begin
                if (tick && (cnt_q == CW'(GAP_TICKS - 1))) begin
                    cnt_d = '0;
                    if (more_s) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = SHOW;
                    end else begin
                        idx_d   = '0;
                        state_d = INPUT;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            INPUT: begin
                if (press_valid_s && (press_val_s == mem_q[idx_q])) begin
                    cnt_d   = '0;
                    state_d = ECHO;
                end else if (press_valid_s) begin
                    cnt_d   = '0;
                    state_d = LOSE;
                end else begin
                    state_d = INPUT;
                end
            end
            ECHO: begin
                if (tick && (cnt_q == CW'(SHOW_TICKS - 1))) begin
                    cnt_d = '0;
                    if (more_s) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = INPUT;
                    end else if (level_q == 5'(MAX_LEN)) begin
                        state_d = WIN;
                    end else begin
                        state_d = ADD;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            LOSE, WIN: begin
                if (!start) begin
                    level_d = 5'd0;
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                level_d = 5'd0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Switching start off abandons whatever is in progress.
        if (fall_s) begin
            state_d  = IDLE;
            level_d  = 5'd0;
            idx_d    = '0;
            cnt_d    = '0;
            mem_we_s = 1'b0;
        end else begin
            state_d = state_d;
        end

        // The entry being written this cycle is not in memory yet, so forward it.
        if (mem_we_s && (mem_widx_s == idx_d)) begin
            show_val_s = lfsr_s[1:0];
        end else begin
            show_val_s = mem_q[idx_d];
        end

        case (state_d)
            IDLE:    color_d = CODE_START;
            ADD:     color_d = CODE_BOARD;
            SHOW:    color_d = entry_to_code(show_val_s);
            GAP:     color_d = CODE_BOARD;
            INPUT: begin
                color_d = CODE_BOARD;
                await_d = 1'b1;
            end
            ECHO:    color_d = (state_q == ECHO) ? color_q : entry_to_code(press_val_s);
            LOSE:    color_d = CODE_LOSE;
            WIN:     color_d = CODE_WIN;
            default: color_d = CODE_START;
        endcase
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= 5'd0;
            idx_q   <= '0;
            cnt_q   <= '0;
            color_q <= CODE_START;
            await_q <= 1'b0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            await_q <= await_d;
            start_q <= start;
        end
    end

    // Sequence memory; contents survive reset and are simply overwritten by the next game.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_widx_s] <= lfsr_s[1:0];
        end
    end

    assign g_color_num    = color_q;
    assign level          = level_q;
    assign awaiting_input = await_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Scoreboard bench for simon_sequencer: an independent LFSR model predicts each new entry,
// expected show/echo codes are queued as rounds are driven and popped as the display produces them.
module tb_simon_sequencer;

    localparam int ML = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       start;
    logic       btn_u, btn_r, btn_d, btn_l;
    logic [7:0] seed;
    logic [3:0] color;
    logic [4:0] level;
    logic       awaiting;

    logic [7:0] m_lfsr, m_prev;
    int         seq[$];
    int         exp_q[$];
    int         n_total = 0;
    int         n_bad   = 0;

    simon_sequencer #(.MAX_LEN(ML), .SHOW_TICKS(4), .GAP_TICKS(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .start          (start),
        .btn_u          (btn_u),
        .btn_r          (btn_r),
        .btn_d          (btn_d),
        .btn_l          (btn_l),
        .seed           (seed),
        .g_color_num    (color),
        .level          (level),
        .awaiting_input (awaiting)
    );

    always #5 clk = ~clk;

    // Reference LFSR; m_prev is the value that was current during the previous clock.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
            m_prev <= (seed == 8'h00) ? 8'h01 : seed;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_btns();
        btn_u = 1'b0; btn_r = 1'b0; btn_d = 1'b0; btn_l = 1'b0;
    endtask

    task automatic drive_btn(input int code);
        case (code)
            1:       btn_u = 1'b1;
            2:       btn_r = 1'b1;
            3:       btn_d = 1'b1;
            4:       btn_l = 1'b1;
            default: clear_btns();
        endcase
    endtask

    // Wait for the level to grow; the entry written in ADD is the LFSR value of that clock.
    task automatic wait_add();
        int lv0;
        lv0 = int'(level);
        for (int k = 0; k < 80; k++) begin
            step();
            if (int'(level) != lv0) begin
                seq.push_back(int'(m_prev[1:0]));
                return;
            end
        end
        check_val("add_timeout", 0, 1);
    endtask

    task automatic watch_show(input int n);
        int e, len;
        foreach (seq[i]) exp_q.push_back(seq[i] + 1);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 40 && color == 4'd0; k++) step();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check_val("show_code", int'(color), e);
            len = 0;
            while (int'(color) == e && len < 20) begin
                len++;
                if (len == 1) btn_u = 1'b1;
                step();
                clear_btns();
            end
            check_val("show_len", len, 4);
            len = 0;
            while (color == 4'd0 && !awaiting && len < 20) begin
                len++;
                step();
            end
            check_val("gap_len", len, 2);
        end
        check_val("await_after_show", int'(awaiting), 1);
        check_val("level_after_show", int'(level), n);
    endtask

    task automatic press_echo(input int code, input bit extra);
        int len;
        exp_q.push_back(code);
        check_val("await_before_press", int'(awaiting), 1);
        drive_btn(code);
        step();
        clear_btns();
        check_val("echo_code", int'(color), exp_q.pop_front());
        len = 0;
        while (int'(color) == code && len < 20) begin
            len++;
            if (extra && len == 2) btn_r = 1'b1;
            step();
            clear_btns();
        end
        check_val("echo_len", len, 4);
    endtask

    // mode 0: perfect round; 1: wrong press on the last entry; 2: u+l together on the first green.
    task automatic play_round(input int n, input int mode, output bit lost, output bit found);
        int code;
        lost  = 1'b0;
        found = 1'b0;
        wait_add();
        check_val("level_new_round", int'(level), n);
        watch_show(n);
        for (int i = 0; i < n; i++) begin
            code = seq[i] + 1;
            if (mode == 1 && i == n - 1) begin
                drive_btn(code % 4 + 1);
                step();
                clear_btns();
                check_val("lose_code", int'(color), 5);
                check_val("lose_level", int'(level), n);
                lost = 1'b1;
                return;
            end
            if (mode == 2 && code == 4) begin
                btn_u = 1'b1;
                btn_l = 1'b1;
                step();
                clear_btns();
                check_val("dual_lose", int'(color), 5);
                check_val("dual_level", int'(level), n);
                lost  = 1'b1;
                found = 1'b1;
                return;
            end
            press_echo(code, i == 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lost, found, found_any;
        rst = 1'b1; tick = 1'b1; start = 1'b0; seed = 8'h00;
        clear_btns();
        step(); step(); step();
        check_val("rst_color", int'(color), 7);
        check_val("rst_level", int'(level), 0);
        check_val("rst_await", int'(awaiting), 0);
        rst = 1'b0;
        step(); step();
        check_val("idle_color", int'(color), 7);

        // Game 1: two good rounds, then a wrong press at level 3.
        start = 1'b1;
        play_round(1, 0, lost, found);
        play_round(2, 0, lost, found);
        play_round(3, 1, lost, found);
        btn_d = 1'b1;
        step();
        clear_btns();
        step();
        check_val("lose_hold", int'(color), 5);
        start = 1'b0;
        step();
        check_val("lose_exit_color", int'(color), 7);
        check_val("lose_exit_level", int'(level), 0);

        // Game 2: simultaneous u+l while green is expected must act as red.
        found_any = 1'b0;
        for (int g = 0; g < 5 && !found_any; g++) begin
            seq.delete();
            start = 1'b1;
            for (int n = 1; n <= ML; n++) begin
                play_round(n, 2, lost, found);
                if (lost) break;
            end
            if (found) found_any = 1'b1;
            start = 1'b0;
            step(); step();
        end
        check_val("dual_found", int'(found_any), 1);

        // Game 3: a perfect game up to MAX_LEN ends in WIN; presses there are ignored.
        seq.delete();
        start = 1'b1;
        for (int n = 1; n <= ML; n++) play_round(n, 0, lost, found);
        check_val("win_code", int'(color), 6);
        check_val("win_level", int'(level), ML);
        btn_u = 1'b1;
        step();
        clear_btns();
        step(); step();
        check_val("win_hold", int'(color), 6);
        check_val("win_hold_level", int'(level), ML);
        start = 1'b0;
        step();
        check_val("win_exit_color", int'(color), 7);
        check_val("win_exit_level", int'(level), 0);

        // Game 4: reset in the middle of a level-5 show, new seed, start held high.
        seq.delete();
        start = 1'b1;
        for (int n = 1; n <= 4; n++) play_round(n, 0, lost, found);
        wait_add();
        check_val("level5", int'(level), 5);
        step(); step();
        seed = 8'h5A;
        rst  = 1'b1;
        #1;
        check_val("midrst_color", int'(color), 7);
        check_val("midrst_level", int'(level), 0);
        check_val("midrst_await", int'(awaiting), 0);
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 30; k++) step();
        check_val("no_restart_color", int'(color), 7);
        check_val("no_restart_level", int'(level), 0);
        start = 1'b0;
        step();
        start = 1'b1;
        seq.delete();
        play_round(1, 0, lost, found);
        play_round(2, 0, lost, found);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
